// File: rtl/atm_account_bank.sv
// Account store answering AUTH/BALANCE/WITHDRAW/DEPOSIT/TRANSFER requests from the ATM controller.
// Entries are scanned one per cycle; all table updates happen on the single EXEC edge.
//
// state | meaning
// IDLE  | ready for provisioning writes or a new request
// SRC   | scanning table for the source account
// DST   | scanning table for the transfer destination
// EXEC  | checks applied, table updated, response registered
// RESP  | response held until rspReady
module atm_account_bank #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 12,
    parameter int PIN_W        = 4,
    parameter int BAL_W        = 11,
    parameter int MAX_TRIES    = 3,
    localparam int IDX_W  = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
    localparam int FAIL_W = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             provValid,
    input  logic [IDX_W-1:0] provIndex,
    input  logic [ACC_W-1:0] provAccNumber,
    input  logic [PIN_W-1:0] provPin,
    input  logic [BAL_W-1:0] provBalance,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [2:0]       reqOp,
    input  logic [ACC_W-1:0] reqAccNumber,
    input  logic [PIN_W-1:0] reqPin,
    input  logic [ACC_W-1:0] reqDestAccNumber,
    input  logic [BAL_W-1:0] reqAmount,
    output logic             rspValid,
    input  logic             rspReady,
    output logic [2:0]       rspStatus,
    output logic [BAL_W-1:0] rspBalance,
    output logic [BAL_W-1:0] rspDestBefore,
    output logic [BAL_W-1:0] rspDestAfter
);

    localparam logic [2:0] OP_AUTH     = 3'd0;
    localparam logic [2:0] OP_BALANCE  = 3'd1;
    localparam logic [2:0] OP_WITHDRAW = 3'd2;
    localparam logic [2:0] OP_DEPOSIT  = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_AUTH = 3'd1;
    localparam logic [2:0] ST_NO_FUNDS = 3'd2;
    localparam logic [2:0] ST_BAD_DEST = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4;
    localparam logic [2:0] ST_BAD_OP   = 3'd5;
    localparam logic [2:0] ST_LOCKED   = 3'd6;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);
    localparam logic [FAIL_W-1:0] LOCK_CNT = FAIL_W'(MAX_TRIES);

    typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_EXEC, S_RESP} state_t;

    state_t state;

    logic              tbl_valid [NUM_ACCOUNTS];
    logic [ACC_W-1:0]  tbl_acc   [NUM_ACCOUNTS];
    logic [PIN_W-1:0]  tbl_pin   [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  tbl_bal   [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] tbl_fail  [NUM_ACCOUNTS];

    logic [2:0]       req_op;
    logic [ACC_W-1:0] req_acc;
    logic [PIN_W-1:0] req_pin;
    logic [ACC_W-1:0] req_dest;
    logic [BAL_W-1:0] req_amount;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W-1:0] dst_idx;
    logic             dst_found;

    logic              src_hit;
    logic              dst_hit;
    logic [2:0]        exec_status;
    logic [BAL_W-1:0]  src_bal_nxt;
    logic [BAL_W-1:0]  dst_bal_nxt;
    logic [FAIL_W-1:0] fail_nxt;
    logic [BAL_W:0]    sum_src;
    logic [BAL_W:0]    sum_dst;
    logic              xfer_ok;

    assign reqReady = (state == S_IDLE) && !provValid;
    assign src_hit  = tbl_valid[scan_idx] && (tbl_acc[scan_idx] == req_acc);
    assign dst_hit  = tbl_valid[scan_idx] && (tbl_acc[scan_idx] == req_dest);
    assign xfer_ok  = (req_op == OP_TRANSFER) && (exec_status == ST_OK);

    always_comb begin
        exec_status = ST_OK;
        src_bal_nxt = tbl_bal[src_idx];
        dst_bal_nxt = tbl_bal[dst_idx];
        fail_nxt    = tbl_fail[src_idx];
        sum_src     = {1'b0, tbl_bal[src_idx]} + {1'b0, req_amount};
        sum_dst     = {1'b0, tbl_bal[dst_idx]} + {1'b0, req_amount};
        if (tbl_fail[src_idx] == LOCK_CNT) begin
            exec_status = ST_LOCKED;
        end else if (tbl_pin[src_idx] != req_pin) begin
            exec_status = ST_BAD_AUTH;
            fail_nxt    = tbl_fail[src_idx] + FAIL_W'(1);
        end else begin
            fail_nxt = '0;
            case (req_op)
                OP_WITHDRAW: begin
                    if (req_amount > tbl_bal[src_idx]) exec_status = ST_NO_FUNDS;
                    else src_bal_nxt = tbl_bal[src_idx] - req_amount;
                end
                OP_DEPOSIT: begin
                    if (sum_src[BAL_W]) exec_status = ST_OVERFLOW;
                    else src_bal_nxt = sum_src[BAL_W-1:0];
                end
                OP_TRANSFER: begin
                    if (!dst_found || (dst_idx == src_idx) || (tbl_fail[dst_idx] == LOCK_CNT))
                        exec_status = ST_BAD_DEST;
                    else if (req_amount > tbl_bal[src_idx])
                        exec_status = ST_NO_FUNDS;
                    else if (sum_dst[BAL_W])
                        exec_status = ST_OVERFLOW;
                    else begin
                        src_bal_nxt = tbl_bal[src_idx] - req_amount;
                        dst_bal_nxt = sum_dst[BAL_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req_op        <= '0;
            req_acc       <= '0;
            req_pin       <= '0;
            req_dest      <= '0;
            req_amount    <= '0;
            scan_idx      <= '0;
            src_idx       <= '0;
            dst_idx       <= '0;
            dst_found     <= 1'b0;
            rspValid      <= 1'b0;
            rspStatus     <= '0;
            rspBalance    <= '0;
            rspDestBefore <= '0;
            rspDestAfter  <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_acc[i]   <= '0;
                tbl_pin[i]   <= '0;
                tbl_bal[i]   <= '0;
                tbl_fail[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (provValid) begin
                        if (int'(provIndex) < NUM_ACCOUNTS) begin
                            tbl_valid[provIndex] <= 1'b1;
                            tbl_acc[provIndex]   <= provAccNumber;
                            tbl_pin[provIndex]   <= provPin;
                            tbl_bal[provIndex]   <= provBalance;
                            tbl_fail[provIndex]  <= '0;
                        end
                    end else if (reqValid) begin
                        req_op     <= reqOp;
                        req_acc    <= reqAccNumber;
                        req_pin    <= reqPin;
                        req_dest   <= reqDestAccNumber;
                        req_amount <= reqAmount;
                        scan_idx   <= '0;
                        dst_found  <= 1'b0;
                        state      <= S_SRC;
                    end
                end
                S_SRC: begin
                    // Illegal opcodes bail out before touching the table.
                    if (req_op > OP_TRANSFER || src_hit || scan_idx == LAST_IDX) begin
                        if (req_op > OP_TRANSFER || !src_hit) begin
                            rspStatus     <= (req_op > OP_TRANSFER) ? ST_BAD_OP : ST_BAD_AUTH;
                            rspBalance    <= '0;
                            rspDestBefore <= '0;
                            rspDestAfter  <= '0;
                            rspValid      <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            src_idx  <= scan_idx;
                            scan_idx <= '0;
                            state    <= (req_op == OP_TRANSFER) ? S_DST : S_EXEC;
                        end
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                S_DST: begin
                    // A missing destination still goes through EXEC so lock/PIN checks take priority.
                    if (dst_hit) begin
                        dst_idx   <= scan_idx;
                        dst_found <= 1'b1;
                        state     <= S_EXEC;
                    end else if (scan_idx == LAST_IDX) begin
                        dst_found <= 1'b0;
                        state     <= S_EXEC;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                S_EXEC: begin
                    tbl_fail[src_idx] <= fail_nxt;
                    tbl_bal[src_idx]  <= src_bal_nxt;
                    if (xfer_ok) tbl_bal[dst_idx] <= dst_bal_nxt;
                    rspStatus     <= exec_status;
                    rspBalance    <= src_bal_nxt;
                    rspDestBefore <= xfer_ok ? tbl_bal[dst_idx] : '0;
                    rspDestAfter  <= xfer_ok ? dst_bal_nxt : '0;
                    rspValid      <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_bank.sv
// Directed bench for atm_account_bank: hand-computed statuses, balances and response latencies.
module tb_atm_account_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        provValid;
    logic [3:0]  provIndex;
    logic [11:0] provAccNumber;
    logic [3:0]  provPin;
    logic [10:0] provBalance;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqOp;
    logic [11:0] reqAccNumber;
    logic [3:0]  reqPin;
    logic [11:0] reqDestAccNumber;
    logic [10:0] reqAmount;
    logic        rspValid;
    logic        rspReady;
    logic [2:0]  rspStatus;
    logic [10:0] rspBalance;
    logic [10:0] rspDestBefore;
    logic [10:0] rspDestAfter;

    int checks = 0;
    int errors = 0;

    int          lat;
    logic [2:0]  st;
    logic [10:0] bal, db, da;

    atm_account_bank dut (
        .clk(clk), .rst_n(rst_n),
        .provValid(provValid), .provIndex(provIndex), .provAccNumber(provAccNumber),
        .provPin(provPin), .provBalance(provBalance),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqAccNumber(reqAccNumber), .reqPin(reqPin), .reqDestAccNumber(reqDestAccNumber),
        .reqAmount(reqAmount),
        .rspValid(rspValid), .rspReady(rspReady), .rspStatus(rspStatus),
        .rspBalance(rspBalance), .rspDestBefore(rspDestBefore), .rspDestAfter(rspDestAfter)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic prov(input logic [3:0] idx, input logic [11:0] acc,
                        input logic [3:0] pin, input logic [10:0] b);
        @(negedge clk);
        provValid = 1'b1; provIndex = idx; provAccNumber = acc; provPin = pin; provBalance = b;
        #1 check("ready_low_during_prov", reqReady, 0);
        @(posedge clk); #1 provValid = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] pin,
                          input logic [11:0] dest, input logic [10:0] amt, input int hold,
                          output int l, output logic [2:0] s, output logic [10:0] b,
                          output logic [10:0] dbf, output logic [10:0] daf);
        @(negedge clk);
        reqValid = 1'b1; reqOp = op; reqAccNumber = acc; reqPin = pin;
        reqDestAccNumber = dest; reqAmount = amt;
        check("req_ready", reqReady, 1);
        @(posedge clk); #1 reqValid = 1'b0;
        l = 0;
        while (!rspValid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        check("rsp_timeout", rspValid, 1);
        s = rspStatus; b = rspBalance; dbf = rspDestBefore; daf = rspDestAfter;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rspValid, 1);
            check("hold_status", rspStatus, s);
            check("hold_balance", rspBalance, b);
        end
        @(negedge clk); rspReady = 1'b1;
        @(posedge clk); #1 rspReady = 1'b0;
        check("rsp_drop", rspValid, 0);
    endtask

    initial begin
        rst_n = 1'b0; provValid = 1'b0; provIndex = '0; provAccNumber = '0; provPin = '0;
        provBalance = '0; reqValid = 1'b0; reqOp = '0; reqAccNumber = '0; reqPin = '0;
        reqDestAccNumber = '0; reqAmount = '0; rspReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", reqReady, 1);
        check("rst_rsp_valid", rspValid, 0);
        check("rst_rsp_status", rspStatus, 0);
        check("rst_rsp_balance", rspBalance, 0);
        @(negedge clk) rst_n = 1'b1;

        prov(4'd0, 12'd2816, 4'd6, 11'd500);
        prov(4'd3, 12'd3467, 4'd3, 11'd200);

        do_req(3'd1, 12'd2816, 4'd6, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("bal_status", st, 0); check("bal_balance", bal, 500); check("bal_latency", lat, 2);
        check("bal_dest_before", db, 0);

        do_req(3'd2, 12'd2816, 4'd6, 12'd0, 11'd505, 0, lat, st, bal, db, da);
        check("wd_nofunds_status", st, 2); check("wd_nofunds_balance", bal, 500);
        do_req(3'd2, 12'd2816, 4'd6, 12'd0, 11'd500, 0, lat, st, bal, db, da);
        check("wd_all_status", st, 0); check("wd_all_balance", bal, 0);
        do_req(3'd3, 12'd2816, 4'd6, 12'd0, 11'd500, 0, lat, st, bal, db, da);
        check("dep500_status", st, 0); check("dep500_balance", bal, 500);

        do_req(3'd4, 12'd2816, 4'd6, 12'd3467, 11'd99, 0, lat, st, bal, db, da);
        check("xfer_status", st, 0); check("xfer_balance", bal, 401);
        check("xfer_dest_before", db, 200); check("xfer_dest_after", da, 299);
        check("xfer_latency", lat, 6);

        do_req(3'd4, 12'd2816, 4'd6, 12'd1334, 11'd10, 0, lat, st, bal, db, da);
        check("xfer_nodest_status", st, 3); check("xfer_nodest_balance", bal, 401);
        check("xfer_nodest_dest_after", da, 0); check("xfer_nodest_latency", lat, 12);
        do_req(3'd4, 12'd2816, 4'd6, 12'd2816, 11'd10, 0, lat, st, bal, db, da);
        check("xfer_self_status", st, 3); check("xfer_self_balance", bal, 401);

        do_req(3'd1, 12'd3467, 4'd3, 12'd0, 11'd0, 5, lat, st, bal, db, da);
        check("dest_bal_status", st, 0); check("dest_bal_balance", bal, 299);
        check("dest_bal_latency", lat, 5);

        do_req(3'd3, 12'd2816, 4'd6, 12'd0, 11'd99, 0, lat, st, bal, db, da);
        check("dep99_balance", bal, 500);
        do_req(3'd3, 12'd2816, 4'd6, 12'd0, 11'd2000, 0, lat, st, bal, db, da);
        check("dep_ovf_status", st, 4); check("dep_ovf_balance", bal, 500);
        do_req(3'd3, 12'd2816, 4'd6, 12'd0, 11'd1547, 0, lat, st, bal, db, da);
        check("dep_max_status", st, 0); check("dep_max_balance", bal, 2047);

        do_req(3'd6, 12'd2816, 4'd6, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("badop_status", st, 5); check("badop_balance", bal, 0); check("badop_latency", lat, 1);

        do_req(3'd0, 12'd999, 4'd1, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("nosrc_status", st, 1); check("nosrc_balance", bal, 0); check("nosrc_latency", lat, 10);

        for (int i = 0; i < 3; i++) begin
            do_req(3'd0, 12'd2816, 4'd9, 12'd0, 11'd0, 0, lat, st, bal, db, da);
            check("badpin_status", st, 1); check("badpin_balance", bal, 2047);
        end
        do_req(3'd0, 12'd2816, 4'd6, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("locked_status", st, 6);
        do_req(3'd3, 12'd2816, 4'd6, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("locked_deposit_status", st, 6); check("locked_deposit_balance", bal, 2047);
        prov(4'd0, 12'd2816, 4'd6, 11'd500);
        do_req(3'd0, 12'd2816, 4'd6, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("reprov_status", st, 0); check("reprov_balance", bal, 500);

        prov(4'd5, 12'd2816, 4'd7, 11'd100);
        do_req(3'd0, 12'd2816, 4'd7, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("dup_lowest_status", st, 1); check("dup_lowest_balance", bal, 500);

        // Transfer 2816 -> 3467: source hits at index 0, then reset lands during the dest scan.
        @(negedge clk);
        reqValid = 1'b1; reqOp = 3'd4; reqAccNumber = 12'd2816; reqPin = 4'd6;
        reqDestAccNumber = 12'd3467; reqAmount = 11'd50;
        @(posedge clk); #1 reqValid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rspValid, 0);
        check("midrst_req_ready", reqReady, 1);
        @(negedge clk) rst_n = 1'b1;
        do_req(3'd1, 12'd3467, 4'd3, 12'd0, 11'd0, 0, lat, st, bal, db, da);
        check("midrst_table_status", st, 1); check("midrst_table_balance", bal, 0);
        check("midrst_table_latency", lat, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
